// File: rtl/output_trace_buffer.sv
// output_trace_buffer
// Captures monitor output activity (two signed values, activity mask and an
// optional cycle timestamp) into a circular FIFO of DEPTH records. Records
// are drained through a valid/ready read port. Overflow is counted and flagged.
// Optional feature macro: TRACE_TS_EN (timestamp counter and storage).
// Without it, rd_ts is tied to zero.
module output_trace_buffer #(
  parameter int DATA_W = 64,
  parameter int TS_W   = 32,
  parameter int DEPTH  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic signed [DATA_W-1:0] output_0,
  input  logic                     output_0_aktv,
  input  logic signed [DATA_W-1:0] output_1,
  input  logic                     output_1_aktv,
  input  logic                     rd_ready,
  input  logic                     clr_overflow,
  output logic                     rd_valid,
  output logic [1:0]               rd_mask,
  output logic signed [DATA_W-1:0] rd_data_0,
  output logic signed [DATA_W-1:0] rd_data_1,
  output logic [TS_W-1:0]          rd_ts,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic [15:0]              drop_count
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = AW + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             r_overflow;
  logic [15:0]      r_drop_count;

  logic signed [DATA_W-1:0] r_mem_d0   [DEPTH];
  logic signed [DATA_W-1:0] r_mem_d1   [DEPTH];
  logic [1:0]               r_mem_mask [DEPTH];

  logic w_valid;
  logic w_full;
  logic w_push_req;
  logic w_pop;
  logic w_push;
  logic w_drop;

  // A full FIFO still accepts a capture when the head leaves on the same edge;
  // the freed slot is exactly the one the write pointer addresses.
  assign w_valid    = (r_count != '0);
  assign w_full     = (r_count == FULL_CNT);
  assign w_push_req = en & (output_0_aktv | output_1_aktv);
  assign w_pop      = w_valid & rd_ready;
  assign w_push     = w_push_req & (~w_full | w_pop);
  assign w_drop     = w_push_req & w_full & ~w_pop;

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Sticky overflow flag and saturating drop counter; a drop beats a clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_overflow   <= 1'b0;
      r_drop_count <= '0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
      if (clr_overflow)
        r_drop_count <= 16'd1;
      else if (r_drop_count != 16'hFFFF)
        r_drop_count <= r_drop_count + 16'd1;
    end else if (clr_overflow) begin
      r_overflow   <= 1'b0;
      r_drop_count <= '0;
    end
  end

  // Record storage; values are kept verbatim regardless of their aktv bit.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_d0[r_wr_ptr]   <= output_0;
      r_mem_d1[r_wr_ptr]   <= output_1;
      r_mem_mask[r_wr_ptr] <= {output_1_aktv, output_0_aktv};
    end
  end

  assign rd_valid   = w_valid;
  assign rd_mask    = w_valid ? r_mem_mask[r_rd_ptr] : 2'b00;
  assign rd_data_0  = w_valid ? r_mem_d0[r_rd_ptr]   : '0;
  assign rd_data_1  = w_valid ? r_mem_d1[r_rd_ptr]   : '0;
  assign count      = r_count;
  assign overflow   = r_overflow;
  assign drop_count = r_drop_count;

`ifdef TRACE_TS_EN
  logic [TS_W-1:0] r_ts;
  logic [TS_W-1:0] r_mem_ts [DEPTH];

  // Free-running cycle timestamp, advancing only while enabled.
  always_ff @(posedge clk) begin
    if (rst)
      r_ts <= '0;
    else if (en)
      r_ts <= r_ts + TS_W'(1);
  end

  // Timestamp storage alongside each record (pre-increment value).
  always_ff @(posedge clk) begin
    if (w_push)
      r_mem_ts[r_wr_ptr] <= r_ts;
  end

  assign rd_ts = w_valid ? r_mem_ts[r_rd_ptr] : '0;
`else
  assign rd_ts = '0;
`endif

endmodule

// File: tb/tb_output_trace_buffer.sv
// Testbench for output_trace_buffer: directed scenarios followed by a
// randomized phase, all checked against a queue-based reference model.
module tb_output_trace_buffer;

  localparam int DATA_W = 64;
  localparam int TS_W   = 32;
  localparam int DEPTH  = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst, en, a0, a1, rdy, clr;
  logic [DATA_W-1:0] d0, d1;

  logic              rd_valid;
  logic [1:0]        rd_mask;
  logic [DATA_W-1:0] rd_data_0, rd_data_1;
  logic [TS_W-1:0]   rd_ts;
  logic [4:0]        count;
  logic              overflow;
  logic [15:0]       drop_count;

  output_trace_buffer #(.DATA_W(DATA_W), .TS_W(TS_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .en(en),
    .output_0(d0), .output_0_aktv(a0),
    .output_1(d1), .output_1_aktv(a1),
    .rd_ready(rdy), .clr_overflow(clr),
    .rd_valid(rd_valid), .rd_mask(rd_mask),
    .rd_data_0(rd_data_0), .rd_data_1(rd_data_1), .rd_ts(rd_ts),
    .count(count), .overflow(overflow), .drop_count(drop_count)
  );

  typedef struct {
    logic [1:0]        mask;
    logic [DATA_W-1:0] v0;
    logic [DATA_W-1:0] v1;
    logic [TS_W-1:0]   ts;
  } rec_t;

  rec_t            q[$];
  logic [TS_W-1:0] m_ts;
  logic            m_ov;
  logic [15:0]     m_dc;

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: one record per active enabled cycle, FIFO as a queue.
  task automatic model_update();
    bit   push_req, pop, drop;
    rec_t r;
    if (rst) begin
      q.delete();
      m_ts = '0;
      m_ov = 1'b0;
      m_dc = '0;
    end else begin
      push_req = en && (a0 || a1);
      pop      = (q.size() > 0) && rdy;
      drop     = push_req && (q.size() == DEPTH) && !pop;
      r.mask = {a1, a0};
      r.v0   = d0;
      r.v1   = d1;
      r.ts   = m_ts;
      if (pop) void'(q.pop_front());
      if (push_req && !drop) q.push_back(r);
      if (drop) begin
        m_ov = 1'b1;
        if (clr) m_dc = 16'd1;
        else if (m_dc != 16'hFFFF) m_dc = m_dc + 16'd1;
      end else if (clr) begin
        m_ov = 1'b0;
        m_dc = '0;
      end
      if (en) m_ts = m_ts + 1;
    end
  endtask

  task automatic check_all();
    rec_t h;
    logic [TS_W-1:0] exp_ts;
    h.mask = '0; h.v0 = '0; h.v1 = '0; h.ts = '0;
    if (q.size() > 0) h = q[0];
`ifdef TRACE_TS_EN
    exp_ts = h.ts;
`else
    exp_ts = '0;
`endif
    check("rd_valid",   64'(rd_valid),   64'(q.size() > 0));
    check("count",      64'(count),      64'(q.size()));
    check("overflow",   64'(overflow),   64'(m_ov));
    check("drop_count", 64'(drop_count), 64'(m_dc));
    check("rd_mask",    64'(rd_mask),    64'(h.mask));
    check("rd_data_0",  rd_data_0,       h.v0);
    check("rd_data_1",  rd_data_1,       h.v1);
    check("rd_ts",      64'(rd_ts),      64'(exp_ts));
  endtask

  task automatic cycle();
    @(posedge clk);
    model_update();
    @(negedge clk);
    check_all();
  endtask

  task automatic drive(input logic e, input logic x0, input logic x1, input logic r,
                       input logic c, input logic [DATA_W-1:0] v0, input logic [DATA_W-1:0] v1);
    en = e; a0 = x0; a1 = x1; rdy = r; clr = c; d0 = v0; d1 = v1;
  endtask

  function automatic logic [DATA_W-1:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  initial begin
    logic [1:0] m;
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, '0, '0);
    m_ts = '0; m_ov = 1'b0; m_dc = '0;

    // Reset state
    cycle();
    cycle();
    rst = 1'b0;

    // Five idle enabled cycles, then a single output_0 capture (ts = 5)
    for (int i = 0; i < 5; i++) begin
      drive(1, 0, 0, 0, 0, rnd64(), rnd64());
      cycle();
    end
    drive(1, 1, 0, 0, 0, 64'd7, '0);
    cycle();

    // Both outputs active with a simultaneous pop, then drain to empty
    drive(1, 1, 1, 1, 0, -64'sd3, 64'd42);
    cycle();
    drive(1, 0, 0, 1, 0, '0, '0);
    cycle();
    drive(1, 0, 0, 0, 0, '0, '0);
    cycle();

    // Overflow: DEPTH+3 captures with no reads
    for (int i = 0; i < DEPTH + 3; i++) begin
      m = 2'($urandom_range(1, 3));
      drive(1, m[0], m[1], 0, 0, rnd64(), rnd64());
      cycle();
    end
    // Drain in order, then clear the overflow status
    for (int i = 0; i < DEPTH; i++) begin
      drive(0, 0, 0, 1, 0, '0, '0);
      cycle();
    end
    drive(0, 0, 0, 0, 1, '0, '0);
    cycle();

    // Refill, then capture and pop on the same edge while full
    for (int i = 0; i < DEPTH; i++) begin
      drive(1, 1, 0, 0, 0, rnd64(), rnd64());
      cycle();
    end
    drive(1, 1, 1, 1, 0, rnd64(), rnd64());
    cycle();
    // Drop coinciding with clr_overflow: the drop wins
    drive(1, 0, 1, 0, 1, rnd64(), rnd64());
    cycle();

    // Disabled with activity high: no captures, reads still drain
    for (int i = 0; i < 10; i++) begin
      drive(0, 1, 1, 1'($urandom_range(1)), 0, rnd64(), rnd64());
      cycle();
    end

    // Mid-operation reset with records stored, then ts restarts at 0
    drive(0, 0, 0, 1, 0, '0, '0);
    for (int i = 0; i < DEPTH; i++) cycle();
    for (int i = 0; i < 4; i++) begin
      drive(1, 1, 1, 0, 0, rnd64(), rnd64());
      cycle();
    end
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    drive(1, 1, 0, 0, 0, rnd64(), rnd64());
    cycle();
    drive(1, 0, 0, 1, 0, '0, '0);
    cycle();

    // Randomized traffic: read-starved first half, read-heavy second half
    for (int i = 0; i < 400; i++) begin
      m = 2'($urandom_range(0, 3));
      rst = ($urandom_range(0, 199) == 0);
      drive(1'($urandom_range(0, 3) != 0), m[0], m[1],
            (i < 200) ? 1'($urandom_range(0, 3) == 0) : 1'($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 31) == 0), rnd64(), rnd64());
      cycle();
    end
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/output_trace_buffer.md
# output_trace_buffer

Downstream capture stage for the generated monitor `topEntity`. Each cycle in which the monitor asserts any output activity flag, this block stores both output values, the activity mask and a cycle timestamp as one record in a FIFO. The host or bench drains the records through a valid/ready read port. Overflow is counted and flagged, never silently lost.

## Interface
Parameters:
- `DATA_W`, 64: width of each monitor output value (signed).
- `TS_W`, 32: timestamp counter width.
- `DEPTH`, 16: FIFO depth in records; power of two, ≥ 2.

Ports:
- `clk` in 1: single clock; all logic is rising-edge.
- `rst` in 1: synchronous, active-high reset.
- `en` in 1: enable, shared with the monitor; gates capture and the timestamp counter.
- `output_0` in DATA_W: monitor output 0 value.
- `output_0_aktv` in 1: output 0 active this cycle.
- `output_1` in DATA_W: monitor output 1 value.
- `output_1_aktv` in 1: output 1 active this cycle.
- `rd_ready` in 1: consumer accepts the head record.
- `clr_overflow` in 1: clears `overflow` and `drop_count`.
- `rd_valid` out 1: head record present.
- `rd_mask` out 2: {output_1_aktv, output_0_aktv} of the head record.
- `rd_data_0` out DATA_W: head output 0 value.
- `rd_data_1` out DATA_W: head output 1 value.
- `rd_ts` out TS_W: head timestamp.
- `count` out log2(DEPTH)+1: records stored.
- `overflow` out 1: sticky; set on any dropped record.
- `drop_count` out 16: dropped records, saturating at 0xFFFF.

## Operation
- Timestamp counter `ts`:
  - Reset to 0; increments by 1 each cycle with `en`=1; holds when `en`=0.
  - Wraps modulo 2^TS_W.
- Capture condition: `en`=1 and (`output_0_aktv` | `output_1_aktv`).
- A captured record holds the current `ts` (pre-increment value), both values and the 2-bit mask.
  - Values are stored verbatim even when the corresponding aktv bit is 0.
- Pop condition: `rd_valid` & `rd_ready`. The read side operates independently of `en`.
- FIFO:
  - Circular buffer; write and read pointers wrap at DEPTH.
  - `count` = occupancy, 0..DEPTH.
- Full (`count`=DEPTH):
  - Capture with no simultaneous pop: record dropped, `overflow` set to 1, `drop_count` incremented (saturating).
  - Capture with a simultaneous pop: record accepted, no drop, `count` unchanged.
- Empty (`count`=0): a simultaneous capture and `rd_ready` does not pop; the record is written.
- `clr_overflow`:
  - Clears `overflow` and `drop_count` next edge.
  - If a drop occurs in the same cycle, the drop wins: `overflow`=1, `drop_count`=1.
- Reset:
  - Pointers, `count`, `ts`, `overflow`, `drop_count` cleared.
  - Mid-operation reset discards all stored records.
  - Reset outputs: `rd_valid`=0, `count`=0, `overflow`=0, `drop_count`=0.
  - Reset outputs: `rd_mask`, `rd_data_0`, `rd_data_1`, `rd_ts` all 0.
- `rd_*` data outputs are 0 whenever `rd_valid`=0.

## Timing
- Capture latency: a record captured at edge N is visible with `rd_valid`=1 after edge N; it is readable in cycle N+1.
- Head data is stable while `rd_valid`=1 and `rd_ready`=0.
- Pop at edge N: the next record, if any, is presented in cycle N+1. Back-to-back pops achieve 1 record per cycle.
- `count` and `overflow` update on the same edge as the push or pop that changes them.
- No combinational path from `rd_ready` to `rd_valid` or to the data outputs.

## Configuration
- `TRACE_TS_EN` defined:
  - Timestamp counter implemented.
  - `rd_ts` carries the captured timestamp.
- `TRACE_TS_EN` undefined:
  - Counter and timestamp storage removed.
  - `rd_ts` tied to 0; port kept for interface stability.
  - All other behaviour unchanged.

## Test plan
- Reset, then `en`=1 for 5 cycles with no activity; pulse `output_0_aktv`=1, `output_0`=7 on cycle 5 → one record: mask=01, data_0=7, ts=5 (with `TRACE_TS_EN`), `count`=1.
- Both aktv set with `output_0`=-3, `output_1`=42, `rd_ready`=1 → mask=11, data_0=-3, data_1=42; record readable one cycle later, then `rd_valid`=0.
- Capture DEPTH+3 records with `rd_ready`=0 → `count`=16, `overflow`=1, `drop_count`=3; drain returns the first 16 in order; `clr_overflow` → both cleared.
- Full FIFO with capture and pop in the same cycle → `count` stays 16, no drop; last record enqueued.
- `en`=0 for 10 cycles with aktv high → no records, `ts` frozen; reads still drain existing records.
- Assert `rst` with 4 records stored → next cycle `rd_valid`=0, `count`=0, `ts` restarts at 0.
